// File: rtl/ex_stage_pipe.sv
// Execute stage: ALU, branch/jump resolution and a multi-cycle multiply feeding
// a registered EX/MEM output with valid/ready handshakes and flush.
module ex_stage_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [2:0]        aluop,
  input  logic              use_rs2,
  input  logic              jump,
  input  logic [REG_W-1:0]  dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] wr_data,
  output logic [REG_W-1:0]  dest_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              taken_o,
  output logic              ovf_o,
  output logic              tgt_err_o
);

  localparam int unsigned CNT_W     = $clog2(MUL_CYCLES) + 1;
  localparam int unsigned DMSB      = DATA_W - 1;
  localparam int unsigned AMSB      = ADDR_W - 1;
  localparam bit          MUL_MULTI = (MUL_CYCLES > 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_OR  = 3'b011,
    OP_AND = 3'b100,
    OP_XOR = 3'b101,
    OP_BZ  = 3'b110,
    OP_BEQ = 3'b111
  } aluop_e;

  typedef enum logic {
    S_IDLE,
    S_MUL_BUSY
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               is_mul_op;
  logic               load_new;
  logic               load_mul;
  logic               stage_en;

  logic [DATA_W-1:0]  opnd2;
  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [ADDR_W-1:0]  br_off;
  logic [ADDR_W-1:0]  br_tgt;
  logic               br_err;
  logic               is_jump;

  logic [DATA_W-1:0]  mul_a;
  logic [DATA_W-1:0]  mul_b;
  logic [DATA_W-1:0]  mul_p;

  logic [DATA_W-1:0]  res_alu;
  logic               res_taken;
  logic               res_ovf;
  logic [ADDR_W-1:0]  res_target;
  logic               res_tgt_err;

  logic [DATA_W-1:0]  stg_a;
  logic [DATA_W-1:0]  stg_opnd2;
  logic [DATA_W-1:0]  stg_b;
  logic [REG_W-1:0]   stg_dest;
  logic [ADDR_W-1:0]  stg_target;
  logic               stg_tgt_err;

  // Operand selection and shared adders
  assign opnd2   = use_rs2 ? op_b : imm;
  assign sum     = op_a + opnd2;
  assign diff    = op_a - opnd2;
  assign add_ovf = (op_a[DMSB] == opnd2[DMSB]) && (sum[DMSB] != op_a[DMSB]);
  assign sub_ovf = (op_a[DMSB] != opnd2[DMSB]) && (diff[DMSB] != op_a[DMSB]);

  // Branch target is always formed, even for untaken and ALU ops
  assign br_off  = imm[AMSB:0] << 2;
  assign br_tgt  = pc_plus4 + br_off;
  assign br_err  = (pc_plus4[AMSB] == br_off[AMSB]) && (br_tgt[AMSB] != pc_plus4[AMSB]);
  assign is_jump = jump && (aluop == OP_ADD);

  // One multiplier: fed from the staging register while a multiply is in flight.
  // Low DATA_W bits of a signed product equal those of the unsigned product.
  assign mul_a = (state_q == S_MUL_BUSY) ? stg_a     : op_a;
  assign mul_b = (state_q == S_MUL_BUSY) ? stg_opnd2 : opnd2;
  assign mul_p = mul_a * mul_b;

  always_comb begin
    res_alu     = '0;
    res_taken   = 1'b0;
    res_ovf     = 1'b0;
    res_target  = is_jump ? op_a[AMSB:0] : br_tgt;
    res_tgt_err = is_jump ? 1'b0 : br_err;
    unique case (aluop_e'(aluop))
      OP_ADD: begin
        res_alu   = sum;
        res_ovf   = add_ovf;
        res_taken = is_jump;
      end
      OP_SUB: begin
        res_alu = diff;
        res_ovf = sub_ovf;
      end
      OP_MUL: res_alu = mul_p;
      OP_OR:  res_alu = op_a | opnd2;
      OP_AND: res_alu = op_a & opnd2;
      OP_XOR: res_alu = op_a ^ opnd2;
      OP_BZ: begin
        res_taken = (op_a == '0);
        res_alu   = {{(DATA_W-1){1'b0}}, res_taken};
      end
      OP_BEQ: begin
        res_taken = (op_a == opnd2);
        res_alu   = {{(DATA_W-1){1'b0}}, res_taken};
      end
      default: res_alu = '0;
    endcase
  end

  // Handshake: accept only when idle and the output register is empty or draining
  assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign is_mul_op = MUL_MULTI && (aluop == OP_MUL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_new = 1'b0;
    load_mul = 1'b0;
    stage_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op) begin
            state_d  = S_MUL_BUSY;
            cnt_d    = CNT_W'(MUL_CYCLES - 1);
            stage_en = 1'b1;
          end else begin
            load_new = 1'b1;
          end
        end
      end
      S_MUL_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          load_mul = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect discards any multiply in flight
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      load_mul = 1'b0;
      stage_en = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stg_a       <= '0;
      stg_opnd2   <= '0;
      stg_b       <= '0;
      stg_dest    <= '0;
      stg_target  <= '0;
      stg_tgt_err <= 1'b0;
    end else if (stage_en) begin
      stg_a       <= op_a;
      stg_opnd2   <= opnd2;
      stg_b       <= op_b;
      stg_dest    <= dest_in;
      stg_target  <= br_tgt;
      stg_tgt_err <= br_err;
    end
  end

  // EX/MEM output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      alu_o     <= '0;
      wr_data   <= '0;
      dest_o    <= '0;
      target_o  <= '0;
      taken_o   <= 1'b0;
      ovf_o     <= 1'b0;
      tgt_err_o <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_new || load_mul) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load_new) begin
        alu_o     <= res_alu;
        wr_data   <= op_b;
        dest_o    <= dest_in;
        target_o  <= res_target;
        taken_o   <= res_taken;
        ovf_o     <= res_ovf;
        tgt_err_o <= res_tgt_err;
      end else if (load_mul) begin
        alu_o     <= mul_p;
        wr_data   <= stg_b;
        dest_o    <= stg_dest;
        target_o  <= stg_target;
        taken_o   <= 1'b0;
        ovf_o     <= 1'b0;
        tgt_err_o <= stg_tgt_err;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed plan items plus random traffic checked
// every cycle against a transaction-level reference model.
module tb_ex_stage_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned MC = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] op_a, op_b, imm;
  logic [AW-1:0] pc_plus4;
  logic [2:0]    aluop;
  logic          use_rs2, jump;
  logic [RW-1:0] dest_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_o, wr_data;
  logic [RW-1:0] dest_o;
  logic [AW-1:0] target_o;
  logic          taken_o, ovf_o, tgt_err_o;

  always #5 clock = ~clock;

  ex_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .MUL_CYCLES(MC)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .imm(imm), .pc_plus4(pc_plus4),
    .aluop(aluop), .use_rs2(use_rs2), .jump(jump), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_o(alu_o), .wr_data(wr_data), .dest_o(dest_o), .target_o(target_o),
    .taken_o(taken_o), .ovf_o(ovf_o), .tgt_err_o(tgt_err_o)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  dest;
    logic [31:0] tgt;
    logic        taken;
    logic        ovf;
    logic        terr;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  bit   m_valid, m_busy;
  int   m_left;
  res_t m_out, m_pend;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit out_rng(input longint v);
    return (v > 64'sh7FFFFFFF) || (v < -64'sh80000000);
  endfunction

  // Reference result computed from arithmetic on true signed values
  function automatic res_t expect_res(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] im,
                                      input logic [31:0] pc, input logic rs2,
                                      input logic jmp, input logic [4:0] d);
    longint      sa, s2, r, pcs;
    logic [31:0] o2, off;
    res_t        x;
    o2 = rs2 ? b : im;
    sa = longint'($signed(a));
    s2 = longint'($signed(o2));
    x = '0;
    x.wd = b;
    x.dest = d;
    case (op)
      3'd0: begin r = sa + s2; x.alu = r[31:0]; x.ovf = out_rng(r); x.taken = jmp; end
      3'd1: begin r = sa - s2; x.alu = r[31:0]; x.ovf = out_rng(r); end
      3'd2: begin r = sa * s2; x.alu = r[31:0]; end
      3'd3: x.alu = a | o2;
      3'd4: x.alu = a & o2;
      3'd5: x.alu = a ^ o2;
      3'd6: begin x.taken = (a == 0); x.alu = {31'd0, x.taken}; end
      default: begin x.taken = (a == o2); x.alu = {31'd0, x.taken}; end
    endcase
    if (op == 3'd0 && jmp) begin
      x.tgt = a;
    end else begin
      off = im * 4;
      pcs = longint'($signed(pc)) + longint'($signed(off));
      x.tgt = pcs[31:0];
      x.terr = out_rng(pcs);
    end
    return x;
  endfunction

  function automatic bit model_ready();
    return !m_busy && (!m_valid || out_ready);
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit   acc;
    res_t r;
    acc = in_valid && model_ready() && !flush;
    r = expect_res(aluop, op_a, op_b, imm, pc_plus4, use_rs2, jump, dest_in);
    if (flush) begin
      m_valid = 0;
      m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_valid = 1;
        m_out = m_pend;
      end
    end else if (acc) begin
      if (aluop == 3'd2 && MC > 1) begin
        m_busy = 1;
        m_left = MC - 1;
        m_pend = r;
        m_valid = 0;
      end else begin
        m_valid = 1;
        m_out = r;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_out();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("alu_o", 64'(alu_o), 64'(m_out.alu));
      chk("wr_data", 64'(wr_data), 64'(m_out.wd));
      chk("dest_o", 64'(dest_o), 64'(m_out.dest));
      chk("target_o", 64'(target_o), 64'(m_out.tgt));
      chk("taken_o", 64'(taken_o), 64'(m_out.taken));
      chk("ovf_o", 64'(ovf_o), 64'(m_out.ovf));
      chk("tgt_err_o", 64'(tgt_err_o), 64'(m_out.terr));
    end
  endtask

  // Called at posedge+1 with inputs driven; returns at the next posedge+1
  task automatic cycle();
    #1;
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    model_step();
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc,
                       input logic rs2, input logic jmp, input logic [4:0] d,
                       input logic fl, input logic ordy);
    in_valid = v; aluop = op; op_a = a; op_b = b; imm = im; pc_plus4 = pc;
    use_rs2 = rs2; jump = jmp; dest_in = d; flush = fl; out_ready = ordy;
  endtask

  task automatic op_cycle(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] pc, input logic rs2,
                          input logic jmp, input logic [4:0] d);
    drive(1, op, a, b, im, pc, rs2, jmp, d, 0, 1);
    cycle();
  endtask

  task automatic idle_cycle(input logic ordy);
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
    cycle();
  endtask

  task automatic do_reset();
    reset_n = 0;
    m_valid = 0;
    m_busy = 0;
    m_left = 0;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h7FFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b, r_im;
    logic        r_rs2;

    reset_n = 0;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", {alu_o, wr_data}, 64'd0);
    chk("rst_target_dest", {27'd0, dest_o, target_o}, 64'd0);
    chk("rst_flags", {61'd0, taken_o, ovf_o, tgt_err_o}, 64'd0);
    @(posedge clock);
    #1;

    op_cycle(3'd0, 32'h7FFFFFFF, 32'h1, 0, 0, 1, 0, 5'd3);
    chk("add_ovf_alu", 64'(alu_o), 64'h80000000);
    chk("add_ovf_flag", {62'd0, out_valid, ovf_o}, 64'd3);
    op_cycle(3'd1, 32'd5, 32'd7, 0, 0, 1, 0, 5'd4);
    chk("sub_alu", 64'(alu_o), 64'hFFFFFFFE);
    chk("sub_ovf", 64'(ovf_o), 64'd0);
    op_cycle(3'd7, 32'd9, 32'd9, 32'hFFFFFFFE, 32'h100, 1, 0, 5'd0);
    chk("beq_res", {62'd0, alu_o[0], taken_o}, 64'd3);
    chk("beq_target", 64'(target_o), 64'hF8);
    op_cycle(3'd6, 32'd3, 0, 0, 0, 1, 0, 5'd0);
    chk("bz_res", {alu_o, 31'd0, taken_o}, 64'd0);
    op_cycle(3'd0, 32'h400, 0, 0, 0, 1, 1, 5'd0);
    chk("jump_taken", 64'(taken_o), 64'd1);
    chk("jump_target", 64'(target_o), 64'h400);
    op_cycle(3'd0, 0, 0, 32'd1, 32'h7FFFFFFC, 0, 0, 5'd0);
    chk("tgt_err", 64'(tgt_err_o), 64'd1);

    // Multiply followed immediately by XOR presented back-to-back
    op_cycle(3'd2, 32'hFFFFFFFD, 32'd7, 0, 32'h40, 1, 0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd5, 32'hF0F0, 32'h0FF0, 0, 0, 1, 0, 5'd10, 0, 1);
      #1 chk("mul_stall", 64'(in_ready), 64'd0);
      cycle();
    end
    chk("mul_result", {31'd0, out_valid, alu_o}, {31'd0, 1'b1, 32'hFFFFFFEB});
    chk("mul_dest", 64'(dest_o), 64'd9);
    cycle();
    chk("xor_after_mul", 64'(alu_o), 64'hFF00);

    // Backpressure then drain with same-cycle accept
    drive(1, 3'd4, 32'hFF, 32'h0F, 0, 0, 1, 0, 5'd11, 0, 0);
    #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("bp_hold", {31'd0, out_valid, alu_o}, {31'd0, 1'b1, 32'hFF00});
    drive(1, 3'd4, 32'hFF, 32'h0F, 0, 0, 1, 0, 5'd11, 0, 1);
    cycle();
    chk("drain_accept", 64'(alu_o), 64'h0F);

    // Flush during a multiply
    op_cycle(3'd2, 32'd6, 32'd7, 0, 0, 1, 0, 5'd1);
    idle_cycle(1);
    drive(1, 3'd0, 32'd1, 32'd1, 0, 0, 1, 0, 5'd2, 1, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      idle_cycle(1);
      chk("flush_no_valid", 64'(out_valid), 64'd0);
    end
    drive(1, 3'd0, 32'd1, 32'd1, 0, 0, 1, 0, 5'd2, 1, 1);
    cycle();
    chk("flush_blocks_accept", 64'(out_valid), 64'd0);
    op_cycle(3'd0, 32'd2, 32'd3, 0, 0, 1, 0, 5'd2);
    chk("after_flush", 64'(alu_o), 64'd5);

    // Reset in the middle of a multiply
    op_cycle(3'd2, 32'd6, 32'd7, 0, 0, 1, 0, 5'd1);
    idle_cycle(1);
    reset_n = 0;
    #1;
    chk("rst_mid_mul_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_mul_valid", 64'(out_valid), 64'd0);
    do_reset();
    for (int i = 0; i < 5; i++) idle_cycle(1);
    op_cycle(3'd2, 32'd6, 32'd7, 0, 0, 1, 0, 5'd1);
    for (int i = 0; i < 3; i++) idle_cycle(1);
    chk("mul_after_reset", {31'd0, out_valid, alu_o}, {31'd0, 1'b1, 32'd42});

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_a   = rnd_val();
      r_b   = rnd_val();
      r_im  = rnd_val();
      r_rs2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        r_b = r_a;
        r_im = r_a;
      end
      drive(1'($urandom_range(0, 9) < 7), r_op, r_a, r_b, r_im, rnd_val(), r_rs2,
            (r_op == 3'd0) ? 1'($urandom_range(0, 1)) : 1'b0, 5'($urandom),
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
